// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state codes, opcodes, DR lengths and instruction decode.
// No logic or latency of its own; the TAP has no backpressure.
package jtag_pkg;

  localparam int IR_LEN      = 4;
  localparam int IDCODE_LEN  = 32;
  localparam int USER_LEN    = 8;
  localparam int OE_LEN      = 8;
  localparam int BYPASS_LEN  = 1;

  localparam logic [IR_LEN-1:0] IR_CAPTURE  = 4'b0101;
  localparam logic [IR_LEN-1:0] OP_IDCODE   = 4'b0001;
  localparam logic [IR_LEN-1:0] OP_USERDATA = 4'b0010;
  localparam logic [IR_LEN-1:0] OP_OEDATA   = 4'b0011;
  localparam logic [IR_LEN-1:0] OP_BYPASS   = 4'b1111;

  localparam logic [3:0] S_TLR     = 4'hF;
  localparam logic [3:0] S_RTI     = 4'hC;
  localparam logic [3:0] S_SELDR   = 4'h7;
  localparam logic [3:0] S_CAPDR   = 4'h6;
  localparam logic [3:0] S_SHDR    = 4'h2;
  localparam logic [3:0] S_EX1DR   = 4'h1;
  localparam logic [3:0] S_PAUSEDR = 4'h3;
  localparam logic [3:0] S_EX2DR   = 4'h0;
  localparam logic [3:0] S_UPDDR   = 4'h5;
  localparam logic [3:0] S_SELIR   = 4'h4;
  localparam logic [3:0] S_CAPIR   = 4'hE;
  localparam logic [3:0] S_SHIR    = 4'hA;
  localparam logic [3:0] S_EX1IR   = 4'h9;
  localparam logic [3:0] S_PAUSEIR = 4'hB;
  localparam logic [3:0] S_EX2IR   = 4'h8;
  localparam logic [3:0] S_UPDIR   = 4'hD;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER, DR_OE} dr_sel_e;

  // Unknown opcodes fall back to BYPASS so the chain length stays defined.
  function automatic dr_sel_e dr_select(input logic [IR_LEN-1:0] ir);
    case (ir)
      OP_IDCODE:   return DR_IDCODE;
      OP_USERDATA: return DR_USER;
      OP_OEDATA:   return DR_OE;
      default:     return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// Tiny Tapeout 8/8/8 pin bundle seen by the TAP (slave) and its driver (master).
// Pure wiring: no latency, no backpressure.
interface jtag_tap_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller stepped by the oversampled TCK rising pulse.
// Advances one state per tck_rise; TRST forces TLR on the next clk; no backpressure.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tck_rise,
  input  logic       i_tms,
  input  logic       i_trst,
  output logic [3:0] o_state,
  output logic [3:0] o_next
);

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_comb begin
    w_next = S_TLR;
    case (r_state)
      S_TLR:     w_next = i_tms ? S_TLR   : S_RTI;
      S_RTI:     w_next = i_tms ? S_SELDR : S_RTI;
      S_SELDR:   w_next = i_tms ? S_SELIR : S_CAPDR;
      S_CAPDR:   w_next = i_tms ? S_EX1DR : S_SHDR;
      S_SHDR:    w_next = i_tms ? S_EX1DR : S_SHDR;
      S_EX1DR:   w_next = i_tms ? S_UPDDR : S_PAUSEDR;
      S_PAUSEDR: w_next = i_tms ? S_EX2DR : S_PAUSEDR;
      S_EX2DR:   w_next = i_tms ? S_UPDDR : S_SHDR;
      S_UPDDR:   w_next = i_tms ? S_SELDR : S_RTI;
      S_SELIR:   w_next = i_tms ? S_TLR   : S_CAPIR;
      S_CAPIR:   w_next = i_tms ? S_EX1IR : S_SHIR;
      S_SHIR:    w_next = i_tms ? S_EX1IR : S_SHIR;
      S_EX1IR:   w_next = i_tms ? S_UPDIR : S_PAUSEIR;
      S_PAUSEIR: w_next = i_tms ? S_EX2IR : S_PAUSEIR;
      S_EX2IR:   w_next = i_tms ? S_UPDIR : S_SHIR;
      S_UPDIR:   w_next = i_tms ? S_SELDR : S_RTI;
      default:   w_next = S_TLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_trst) begin
      r_state <= S_TLR;
    end else if (i_tck_rise) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;
  assign o_next  = w_next;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with IR and IDCODE/BYPASS/USERDATA/OEDATA DRs, pins oversampled on clk.
// Pin edges act SYNC_STAGES+1 clks later; TCK phases need >= 4 clks; no backpressure.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter logic [IDCODE_LEN-1:0] IDCODE      = 32'h1234_5A5B,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  jtag_tap_if.slave  pins
);

  logic [3:0]            r_sync [SYNC_STAGES];
  logic                  r_tck_q;
  logic                  w_tck, w_tms, w_tdi, w_trst, w_rise, w_fall;
  logic [3:0]            w_state, w_next;
  logic [IR_LEN-1:0]     r_ir, r_ir_sr;
  logic [IDCODE_LEN-1:0] r_id_sr;
  logic [USER_LEN-1:0]   r_user_sr, r_uio_out;
  logic [OE_LEN-1:0]     r_oe_sr, r_uio_oe;
  logic                  r_bypass_sr;
  logic                  r_tdo;
  logic                  w_dr_lsb, w_tdo_en;
  dr_sel_e               w_sel;
  logic                  w_unused;

  assign w_unused = &{1'b0, ena, pins.ui_in[7:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_tck_q <= 1'b0;
    end else begin
      r_sync[0] <= pins.ui_in[3:0];
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_tck_q <= w_tck;
    end
  end

  assign w_tck  = r_sync[SYNC_STAGES-1][0];
  assign w_tms  = r_sync[SYNC_STAGES-1][1];
  assign w_tdi  = r_sync[SYNC_STAGES-1][2];
  assign w_trst = ~r_sync[SYNC_STAGES-1][3];
  assign w_rise = w_tck & ~r_tck_q;
  assign w_fall = ~w_tck & r_tck_q;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_tck_rise (w_rise),
    .i_tms      (w_tms),
    .i_trst     (w_trst),
    .o_state    (w_state),
    .o_next     (w_next)
  );

  // IR loads on entry to UpdIR / TLR, i.e. in the same clk as the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir    <= OP_IDCODE;
      r_ir_sr <= '0;
    end else if (w_trst) begin
      r_ir <= OP_IDCODE;
    end else if (w_rise) begin
      if (w_state == S_CAPIR)     r_ir_sr <= IR_CAPTURE;
      else if (w_state == S_SHIR) r_ir_sr <= {w_tdi, r_ir_sr[IR_LEN-1:1]};
      if (w_next == S_UPDIR)      r_ir <= r_ir_sr;
      else if (w_next == S_TLR)   r_ir <= OP_IDCODE;
    end
  end

  assign w_sel = dr_select(r_ir);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_sr     <= '0;
      r_bypass_sr <= 1'b0;
      r_user_sr   <= '0;
      r_oe_sr     <= '0;
      r_uio_out   <= '0;
      r_uio_oe    <= '0;
    end else if (w_rise && !w_trst) begin
      if (w_state == S_CAPDR) begin
        case (w_sel)
          DR_IDCODE: r_id_sr     <= IDCODE;
          DR_USER:   r_user_sr   <= pins.uio_in;
          DR_OE:     r_oe_sr     <= r_uio_oe;
          default:   r_bypass_sr <= 1'b0;
        endcase
      end else if (w_state == S_SHDR) begin
        case (w_sel)
          DR_IDCODE: r_id_sr     <= {w_tdi, r_id_sr[IDCODE_LEN-1:1]};
          DR_USER:   r_user_sr   <= {w_tdi, r_user_sr[USER_LEN-1:1]};
          DR_OE:     r_oe_sr     <= {w_tdi, r_oe_sr[OE_LEN-1:1]};
          default:   r_bypass_sr <= w_tdi;
        endcase
      end else if (w_state == S_UPDDR) begin
        if (w_sel == DR_USER)    r_uio_out <= r_user_sr;
        else if (w_sel == DR_OE) r_uio_oe  <= r_oe_sr;
      end
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass_sr;
    case (w_sel)
      DR_IDCODE: w_dr_lsb = r_id_sr[0];
      DR_USER:   w_dr_lsb = r_user_sr[0];
      DR_OE:     w_dr_lsb = r_oe_sr[0];
      default:   w_dr_lsb = r_bypass_sr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdo <= 1'b0;
    end else if (w_fall) begin
      if (w_state == S_SHIR)      r_tdo <= r_ir_sr[0];
      else if (w_state == S_SHDR) r_tdo <= w_dr_lsb;
    end
  end

  assign w_tdo_en     = (w_state == S_SHDR) || (w_state == S_SHIR);
  assign pins.uo_out  = {w_state, 2'b00, w_tdo_en, r_tdo};
  assign pins.uio_out = r_uio_out;
  assign pins.uio_oe  = r_uio_oe;

endmodule

// File: tb/tb_jtag_tap.sv
// Scoreboarded bench for jtag_tap: stimulus queues expected TDO bits, a monitor
// compares them after each TCK fall while the DUT flags TDO enable.
module tb_jtag_tap;

  localparam int          SYNC   = 2;
  localparam logic [31:0] IDCODE = 32'h1234_5A5B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       tck = 1'b0, tms = 1'b0, tdi = 1'b0, trst_n = 1'b1;
  logic [7:0] uio_in_v = 8'h00;
  int         checks = 0;
  int         errors = 0;
  logic       exp_q[$];

  jtag_tap_if pins();
  assign pins.ui_in  = {4'h0, trst_n, tdi, tms, tck};
  assign pins.uio_in = uio_in_v;

  jtag_tap #(.IDCODE(IDCODE), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .pins (pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: the TDO update lands SYNC+1 clks after the pin fall.
  initial begin
    logic e;
    forever begin
      @(negedge tck);
      repeat (SYNC + 1) @(posedge clk);
      @(negedge clk);
      if (pins.uo_out[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tdo_unexpected actual=%b expected=none", pins.uo_out[0]);
        end else begin
          e = exp_q.pop_front();
          check("tdo", {31'd0, pins.uo_out[0]}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic tck_cycle(input logic tms_v, input logic tdi_v);
    @(negedge clk);
    tms = tms_v;
    tdi = tdi_v;
    tck = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [3:0] exp);
    check(name, {28'd0, pins.uo_out[7:4]}, {28'd0, exp});
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  // From RTI; the capture pattern 0101 comes out first.
  task automatic shift_ir(input logic [3:0] op);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    push_bits(32'h5, 4);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, op[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check_state("ir_rti", 4'hC);
  endtask

  task automatic shift_dr(input logic [31:0] din, input int n, input logic [31:0] exp);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    push_bits(exp, n);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, din[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check_state("dr_rti", 4'hC);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_uo_out", {24'd0, pins.uo_out}, 32'hF0);
    check("rst_uio_out", {24'd0, pins.uio_out}, 32'h00);
    check("rst_uio_oe", {24'd0, pins.uio_oe}, 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    check_state("tlr_hold", 4'hF);

    tck_cycle(1'b0, 1'b0); check_state("st_rti", 4'hC);
    tck_cycle(1'b1, 1'b0); check_state("st_seldr", 4'h7);
    tck_cycle(1'b0, 1'b0); check_state("st_capdr", 4'h6);
    push_bits(IDCODE, 32);
    tck_cycle(1'b0, 1'b0); check_state("st_shdr", 4'h2);
    for (int i = 0; i < 32; i++) tck_cycle(i == 31, 1'b0);
    tck_cycle(1'b1, 1'b0); check_state("st_upddr", 4'h5);
    tck_cycle(1'b0, 1'b0); check_state("st_rti2", 4'hC);

    shift_ir(4'b0010);
    shift_dr(32'hA5, 8, 32'h00);
    check("user_upd", {24'd0, pins.uio_out}, 32'hA5);

    shift_ir(4'b0011);
    shift_dr(32'hFF, 8, 32'h00);
    check("oe_upd", {24'd0, pins.uio_oe}, 32'hFF);
    shift_dr(32'h0F, 8, 32'hFF);
    check("oe_upd2", {24'd0, pins.uio_oe}, 32'h0F);
    check("user_keep", {24'd0, pins.uio_out}, 32'hA5);

    shift_ir(4'b0010);
    uio_in_v = 8'h3C;
    shift_dr(32'h5A, 8, 32'h3C);
    check("user_upd2", {24'd0, pins.uio_out}, 32'h5A);

    shift_ir(4'b1111);
    shift_dr(32'hB2, 8, 32'h64);
    shift_ir(4'b0110);
    shift_dr(32'h4D, 8, 32'h9A);
    check("byp_keep_out", {24'd0, pins.uio_out}, 32'h5A);
    check("byp_keep_oe", {24'd0, pins.uio_oe}, 32'h0F);

    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    shift_dr(32'h0, 32, IDCODE);

    shift_ir(4'b0010);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    push_bits(32'h0, 2);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    check_state("pre_trst", 4'h2);
    @(negedge clk);
    trst_n = 1'b0;
    repeat (SYNC) @(negedge clk);
    check_state("trst_lat", 4'h2);
    @(negedge clk);
    check_state("trst_tlr", 4'hF);
    check("trst_uio_out", {24'd0, pins.uio_out}, 32'h5A);
    check("trst_uio_oe", {24'd0, pins.uio_oe}, 32'h0F);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0);
    shift_dr(32'h0, 32, IDCODE);

    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    tck_cycle(1'b0, 1'b0);
    check("shir_out", {24'd0, pins.uo_out}, 32'hA3);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_uo_out", {24'd0, pins.uo_out}, 32'hF0);
    check("rst2_uio_out", {24'd0, pins.uio_out}, 32'h00);
    check("rst2_uio_oe", {24'd0, pins.uio_oe}, 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0);
    shift_dr(32'h0, 32, IDCODE);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
Name: jtag_tap

Overview:
- IEEE 1149.1-style JTAG Test Access Port packaged as a Tiny Tapeout user block with the standard 8/8/8 pin interface.
- JTAG pins (TCK/TMS/TDI/TRST_N) are oversampled on the system clock and edge-detected; no second clock domain exists.
- Provides a 16-state TAP controller, a 4-bit IR, and IDCODE/BYPASS/USERDATA/OEDATA data registers.
- USERDATA and OEDATA drive the bidirectional uio pins.

Parameters:
- IDCODE, 32'h1234_5A5B, value loaded by Capture-DR under IDCODE; bit0 must be 1.
- SYNC_STAGES, 2, synchronizer flops on ui_in[3:0].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design-selected flag; ignored.
- ui_in  in  8  [0]=TCK, [1]=TMS, [2]=TDI, [3]=TRST_N (active low); [7:4] unused.
- uo_out  out  8  [0]=TDO, [1]=TDO enable (high in Shift-DR/Shift-IR), [3:2]=0, [7:4]=TAP state code.
- uio_in  in  8  parallel input captured into USERDATA.
- uio_out  out  8  USERDATA update register.
- uio_oe  out  8  OEDATA update register.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=TLR (4'hF); IR=IDCODE (4'b0001).
  - All shift registers 0; uio_out=0; uio_oe=0; TDO=0.
  - Synchronizers cleared with TCK=0.
- Synchronization:
  - ui_in[3:0] passes through SYNC_STAGES flops.
  - tck_rise/tck_fall are single-clk pulses from the synced TCK versus its registered copy.
  - A TCK pin edge acts SYNC_STAGES+1 clks later.
  - TMS/TDI use the same synced sample as the TCK edge.
  - TCK high and low phases must each be at least 4 clks.
- TRST_N=0 (synced) forces TLR and IR=IDCODE on the next clk; this is level-sensitive and takes priority over TCK.
- TAP FSM advances on tck_rise per the standard 1149.1 graph using TMS.
  - Encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
  - Five tck_rise with TMS=1 from any state reach TLR.
- Actions on tck_rise, taken in the current state before the transition:
  - CapIR: IR shift register loads 4'b0101.
  - ShIR: shift right; TDI enters the MSB.
  - UpdIR (on entry, same clk as the transition): IR becomes the shift register value.
  - CapDR: selected DR loads its capture value (IDCODE parameter; BYPASS 0; USERDATA uio_in; OEDATA current uio_oe).
  - ShDR: selected DR shifts right, LSB first out, TDI into the MSB.
  - UpdDR: USERDATA copies to uio_out, or OEDATA copies to uio_oe.
  - TLR entry: IR=IDCODE.
- Instructions: 0001 IDCODE (32-bit), 0010 USERDATA (8-bit), 0011 OEDATA (8-bit), 1111 BYPASS (1-bit). Every other code selects BYPASS.
- TDO:
  - Updates on tck_fall to the LSB of the active shift register (IR in ShIR, selected DR in ShDR), otherwise holds.
  - Enable reflects the current state combinationally.
- uo_out[7:4] shows the state register directly, with no TCK alignment.
- Update registers change only in UpdDR or on reset; Pause/Exit states preserve shift contents.

Decomposition:
- Package jtag_pkg:
  - TAP state enum with the encoding above.
  - Instruction opcodes, IR_LEN=4, IR_CAPTURE=4'b0101.
  - DR lengths.
- One natural sub-module: jtag_tap_fsm (state register plus next-state logic, inputs tck_rise/tms/trst).
- Synchronizers, IR, and DRs stay in the top.

Test Plan:
- rst pulse: uo_out[7:4]=F, uio_oe=00, uio_out=00; 5 TCKs with TMS=1 keep state F.
- TMS sequence 0,1,0,0 from TLR: states C,7,6,2 appear on uo_out[7:4]; 32 ShDR clocks shift out 0x12345A5B LSB first on TDO.
- Load IR=0010, write DR 8'hA5, pass UpdDR: uio_out=A5. Load IR=0011, write 8'hFF: uio_oe=FF. Set uio_in=3C, capture and shift: TDO bits yield 0x3C.
- IR=1111 and IR=0110: TDO is TDI delayed by exactly one TCK; ShIR capture shifts out 0101 LSB first.
- TRST_N low mid-ShDR: state F within SYNC_STAGES+1 clks, IR=IDCODE, uio_out/uio_oe unchanged.
- rst asserted mid-ShIR: all outputs return to reset values on the next clk edge.
